// File: rtl/qpsk_awgn_top.sv
// qpsk_awgn_top: PRBS9-driven QPSK mapper feeding an additive Gaussian-noise channel, S(9,7) samples.
// Build with AWGN_EN defined to include the noise path; without it rx is the clean symbol delayed one clock.
module qpsk_awgn_top #(
  parameter int DWIDTH    = 9,
  parameter int SNR_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [SNR_WIDTH-1:0] sigma_scale,
  output logic signed [DWIDTH-1:0]    rx_I,
  output logic signed [DWIDTH-1:0]    rx_Q
);

  localparam logic [8:0]               PRBS_SEED_I = 9'h1AA;
  localparam logic [8:0]               PRBS_SEED_Q = 9'h0FE;
  localparam logic signed [DWIDTH-1:0] AMP         = DWIDTH'(91);

  function automatic logic signed [DWIDTH-1:0] map_bit(input logic b);
    return b ? -AMP : AMP;
  endfunction

  logic [8:0]               prbs_i, prbs_q;
  logic                     bit_i, bit_q;
  logic signed [DWIDTH-1:0] tx_I_internal, tx_Q_internal;

  // Fibonacci x^9+x^5+1: the bit shifted in this clock is the bit mapped this clock.
  assign bit_i = prbs_i[8] ^ prbs_i[4];
  assign bit_q = prbs_q[8] ^ prbs_q[4];

`ifdef AWGN_EN
  localparam int                PW          = 10 + SNR_WIDTH;
  localparam int                SW          = PW + 1;
  localparam logic [31:0]       NOISE_POLY  = 32'h80200003;
  localparam logic [31:0]       NOISE_SEED_I = 32'hACE12345;
  localparam logic [31:0]       NOISE_SEED_Q = 32'h12345678;
  localparam logic signed [SW-1:0] RX_MAX   = SW'(2 ** (DWIDTH - 1) - 1);
  localparam logic signed [SW-1:0] RX_MIN   = SW'(-(2 ** (DWIDTH - 1)));

  function automatic logic [31:0] lfsr_adv8(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int n = 0; n < 8; n++) r = r[0] ? ((r >> 1) ^ NOISE_POLY) : (r >> 1);
    return r;
  endfunction

  // Sum of four signed bytes approximates a Gaussian with std ~148.
  function automatic logic signed [9:0] gauss(input logic [31:0] s);
    logic signed [9:0] acc;
    acc = '0;
    for (int n = 0; n < 4; n++) acc = acc + {{2{s[8*n+7]}}, s[8*n +: 8]};
    return acc;
  endfunction

  function automatic logic signed [DWIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > RX_MAX) return RX_MAX[DWIDTH-1:0];
    if (v < RX_MIN) return RX_MIN[DWIDTH-1:0];
    return v[DWIDTH-1:0];
  endfunction

  logic [31:0]                 lfsr_i, lfsr_q;
  logic signed [SNR_WIDTH-1:0] scale;
  logic signed [PW-1:0]        prod_i, prod_q;
  logic signed [PW-1:0]        noise_i_p0, noise_q_p0;

  always_comb begin
    scale  = sigma_scale[SNR_WIDTH-1] ? '0 : sigma_scale;
    prod_i = PW'(gauss(lfsr_i)) * PW'(scale);
    prod_q = PW'(gauss(lfsr_q)) * PW'(scale);
  end

  // Stage 1: noise product registered alongside the tx symbol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_i     <= NOISE_SEED_I;
      lfsr_q     <= NOISE_SEED_Q;
      noise_i_p0 <= '0;
      noise_q_p0 <= '0;
    end else begin
      lfsr_i     <= lfsr_adv8(lfsr_i);
      lfsr_q     <= lfsr_adv8(lfsr_q);
      noise_i_p0 <= prod_i >>> 10;
      noise_q_p0 <= prod_q >>> 10;
    end
  end
`else
  logic unused_sigma;
  assign unused_sigma = ^sigma_scale;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prbs_i        <= PRBS_SEED_I;
      prbs_q        <= PRBS_SEED_Q;
      tx_I_internal <= '0;
      tx_Q_internal <= '0;
      rx_I          <= '0;
      rx_Q          <= '0;
    end else begin
      prbs_i        <= {prbs_i[7:0], bit_i};
      prbs_q        <= {prbs_q[7:0], bit_q};
      tx_I_internal <= map_bit(bit_i);
      tx_Q_internal <= map_bit(bit_q);
      // Stage 2: received sample from the stage-1 symbol and noise.
`ifdef AWGN_EN
      rx_I          <= sat(SW'(tx_I_internal) + SW'(noise_i_p0));
      rx_Q          <= sat(SW'(tx_Q_internal) + SW'(noise_q_p0));
`else
      rx_I          <= tx_I_internal;
      rx_Q          <= tx_Q_internal;
`endif
    end
  end

endmodule

// File: tb/tb_qpsk_awgn_top.sv
// Directed bench for qpsk_awgn_top: reset state, first symbols, delay, period, noise scaling, reset replay.
module tb_qpsk_awgn_top;
  localparam int DW = 9;
  localparam int SW = 11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [SW-1:0] sigma_scale = '0;
  logic signed [DW-1:0] rx_I, rx_Q;

  int checks = 0;
  int errors = 0;
  int txi_hist [0:599];
  int txq_hist [0:599];
  int rxi_run1 [0:39];
  int rxq_run1 [0:39];
  // First five symbols worked out by hand from seeds 0x1AA / 0x0FE.
  int exp_i [0:4] = '{-91, 91, 91, 91, 91};
  int exp_q [0:4] = '{-91, 91, 91, 91, -91};

  always #5 clk = ~clk;

  qpsk_awgn_top #(.DWIDTH(DW), .SNR_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .sigma_scale(sigma_scale), .rx_I(rx_I), .rx_Q(rx_Q)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accumulates rx - tx(previous cycle) on both rails over n cycles.
  task automatic measure(input int n, output real mean, output real variance, output int pinned);
    int  pi, pq, d;
    longint s, ss;
    s = 0; ss = 0; pinned = 0;
    pi = dut.tx_I_internal;
    pq = dut.tx_Q_internal;
    for (int k = 0; k < n; k++) begin
      step();
      d = int'(rx_I) - pi; s += d; ss += longint'(d) * d;
      d = int'(rx_Q) - pq; s += d; ss += longint'(d) * d;
      if (rx_I == 255 || rx_I == -256) pinned++;
      if (rx_Q == 255 || rx_Q == -256) pinned++;
      pi = dut.tx_I_internal;
      pq = dut.tx_Q_internal;
    end
    mean     = real'(s) / (2.0 * n);
    variance = real'(ss) / (2.0 * n) - mean * mean;
  endtask

  task automatic check_passthrough(input string tag, input int n);
    int pi, pq;
    pi = dut.tx_I_internal;
    pq = dut.tx_Q_internal;
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_I"}, rx_I, pi);
      chk({tag, "_Q"}, rx_Q, pq);
      pi = dut.tx_I_internal;
      pq = dut.tx_Q_internal;
    end
  endtask

  initial begin
    real mean, variance;
    int  pinned, a;

    rst = 1'b0;
    sigma_scale = '0;
    repeat (10) step();
    chk("reset_rx_I", rx_I, 0);
    chk("reset_rx_Q", rx_Q, 0);
    chk("reset_tx_I", dut.tx_I_internal, 0);
    chk("reset_tx_Q", dut.tx_Q_internal, 0);

    rst = 1'b1;
    for (int i = 1; i < 600; i++) begin
      step();
      txi_hist[i] = dut.tx_I_internal;
      txq_hist[i] = dut.tx_Q_internal;
      if (i <= 5) begin
        chk("first_tx_I", txi_hist[i], exp_i[i-1]);
        chk("first_tx_Q", txq_hist[i], exp_q[i-1]);
      end
      if (i == 1) begin
        chk("rx_I_first_edge", rx_I, 0);
        chk("rx_Q_first_edge", rx_Q, 0);
      end else begin
        chk("rx_I_delay", rx_I, txi_hist[i-1]);
        chk("rx_Q_delay", rx_Q, txq_hist[i-1]);
      end
      a = (txi_hist[i] < 0) ? -txi_hist[i] : txi_hist[i];
      chk("tx_I_level", a, 91);
      a = (txq_hist[i] < 0) ? -txq_hist[i] : txq_hist[i];
      chk("tx_Q_level", a, 91);
      if (i > 511) begin
        chk("tx_I_period", txi_hist[i], txi_hist[i-511]);
        chk("tx_Q_period", txq_hist[i], txq_hist[i-511]);
      end
      if (i <= 40) begin
        rxi_run1[i-1] = rx_I;
        rxq_run1[i-1] = rx_Q;
      end
    end

`ifdef AWGN_EN
    sigma_scale = 11'sd200;
    step(); step();
    measure(2000, mean, variance, pinned);
    chk("s200_mean_small", int'(mean > -5.0 && mean < 5.0), 1);
    chk("s200_std_25_33", int'(variance > 625.0 && variance < 1089.0), 1);
    chk("s200_no_sat", pinned, 0);

    sigma_scale = 11'sd800;
    step(); step();
    measure(1000, mean, variance, pinned);
    chk("s800_saturates", int'(pinned > 0), 1);
    chk("s800_std_large", int'(variance > 6400.0), 1);

    sigma_scale = -11'sd300;
    step(); step();
    check_passthrough("neg_sigma", 100);
`else
    sigma_scale = 11'sd800;
    step(); step();
    check_passthrough("sigma_ignored", 100);
`endif

    // Reset and a sigma change land on the same edge; reset must win.
    rst = 1'b0;
    sigma_scale = 11'sd500;
    step();
    chk("midreset_rx_I", rx_I, 0);
    chk("midreset_rx_Q", rx_Q, 0);
    chk("midreset_tx_I", dut.tx_I_internal, 0);
    chk("midreset_tx_Q", dut.tx_Q_internal, 0);
    repeat (3) step();
    sigma_scale = '0;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("replay_rx_I", rx_I, rxi_run1[i]);
      chk("replay_rx_Q", rx_Q, rxq_run1[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
